// File: rtl/tick_gen_pkg.sv
// Shared constants and mode encodings for the tick generator.
// Import this package into both the design and the bench.
package tick_gen_pkg;

  localparam int     CNT_W_DEFAULT  = 26;
  localparam longint DIV_1HZ_50MHZ  = 50_000_000;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

endpackage

// File: rtl/tick_gen.sv
// Programmable tick divider: one-cycle tick every div_q enabled cycles,
// with an optional 50% duty square wave that toggles on each tick.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int     CNT_W       = CNT_W_DEFAULT,
  parameter longint DIV_DEFAULT = DIV_1HZ_50MHZ
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o,
  output logic             clk_o,
  output logic [CNT_W-1:0] cnt_o
);

  if (DIV_DEFAULT <= 0 || DIV_DEFAULT >= (longint'(1) << CNT_W)) begin : g_bad_div
    $fatal(1, "tick_gen: DIV_DEFAULT must lie in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_clk;

  logic [CNT_W-1:0] w_div_ld;
  logic             w_term;
  logic             w_square;

  // A divisor of 0 behaves like 1 so the terminal compare never underflows.
  assign w_div_ld = (div_i == '0) ? CNT_W'(1) : div_i;
  assign w_term   = (r_cnt == r_div - CNT_W'(1));
  assign w_square = (mode_e'(mode_i) == MODE_SQUARE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div  <= DIV_RST;
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_clk  <= 1'b0;
    end else if (load_i) begin
      r_div  <= w_div_ld;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= en_i && w_term;
      if (en_i) begin
        r_cnt <= w_term ? '0 : r_cnt + CNT_W'(1);
      end
      // Pulse mode parks clk_o low, so entering square mode starts from 0.
      if (!w_square) begin
        r_clk <= 1'b0;
      end else if (en_i && w_term) begin
        r_clk <= ~r_clk;
      end
    end
  end

  assign tick_o = r_tick;
  assign clk_o  = r_clk;
  assign cnt_o  = r_cnt;

endmodule

// File: tb/tb_tick_gen.sv
// Directed and randomized bench for tick_gen (CNT_W=4, DIV_DEFAULT=15)
// against an enabled-step-count reference model.
module tb_tick_gen;
  import tick_gen_pkg::*;

  localparam int CW = 4;
  localparam int DD = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic          load;
  logic [CW-1:0] div;
  logic          tick;
  logic          clko;
  logic [CW-1:0] cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: active divisor, enabled steps since restart,
  // toggles since square mode was (re)entered, last tick.
  int m_div;
  int m_n;
  int m_tog;
  int m_tick;

  tick_gen #(.CNT_W(CW), .DIV_DEFAULT(DD)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .mode_i (mode),
    .load_i (load),
    .div_i  (div),
    .tick_o (tick),
    .clk_o  (clko),
    .cnt_o  (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_cnt"},  32'(cnt),  32'(m_n % m_div));
    chk({tag, "_tick"}, 32'(tick), 32'(m_tick));
    chk({tag, "_clk"},  32'(clko), 32'(m_tog % 2));
  endtask

  task automatic model_reset();
    m_div  = DD;
    m_n    = 0;
    m_tog  = 0;
    m_tick = 0;
  endtask

  task automatic model_edge(input logic e, input logic m, input logic l, input int d);
    if (l) begin
      m_div  = (d == 0) ? 1 : d;
      m_n    = 0;
      m_tick = 0;
    end else begin
      if (e) begin
        m_n++;
        m_tick = (m_n % m_div == 0) ? 1 : 0;
      end else begin
        m_tick = 0;
      end
      if (m == MODE_PULSE) m_tog = 0;
      else if (m_tick == 1) m_tog++;
    end
  endtask

  task automatic step(input string tag, input logic e, input logic m,
                      input logic l, input int d);
    en   = e;
    mode = m;
    load = l;
    div  = d[CW-1:0];
    @(posedge clk);
    model_edge(e, m, l, d);
    #1;
    check_all(tag);
    load = 1'b0;
  endtask

  initial begin
    logic cur_mode;
    rst  = 1'b1;
    en   = 1'b0;
    mode = 1'b0;
    load = 1'b0;
    div  = '0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Default divisor from reset: first tick on the 15th edge.
    for (int i = 0; i < 32; i++) step("dflt", 1'b1, MODE_PULSE, 1'b0, 0);

    // Divide by 4 in pulse mode.
    step("ld4", 1'b1, MODE_PULSE, 1'b1, 4);
    for (int i = 0; i < 10; i++) step("div4", 1'b1, MODE_PULSE, 1'b0, 0);

    // Square mode, divide by 3.
    step("ld3", 1'b1, MODE_SQUARE, 1'b1, 3);
    for (int i = 0; i < 14; i++) step("sq3", 1'b1, MODE_SQUARE, 1'b0, 0);
    step("sq2pulse", 1'b1, MODE_PULSE, 1'b0, 0);

    // Enable gating at cnt=2 with divisor 5.
    step("ld5", 1'b1, MODE_PULSE, 1'b1, 5);
    for (int i = 0; i < 2; i++) step("run5", 1'b1, MODE_PULSE, 1'b0, 0);
    for (int i = 0; i < 7; i++) step("hold5", 1'b0, MODE_PULSE, 1'b0, 0);
    for (int i = 0; i < 4; i++) step("resume5", 1'b1, MODE_PULSE, 1'b0, 0);

    // Divisor 0 and 1: tick every enabled cycle.
    step("ld0", 1'b1, MODE_PULSE, 1'b1, 0);
    for (int i = 0; i < 5; i++) step("div0", 1'b1, MODE_PULSE, 1'b0, 0);
    step("div0_off", 1'b0, MODE_PULSE, 1'b0, 0);
    step("ld1", 1'b0, MODE_SQUARE, 1'b1, 1);
    for (int i = 0; i < 5; i++) step("div1", 1'b1, MODE_SQUARE, 1'b0, 0);

    // Load on the terminal-count cycle wins: no tick, no toggle.
    step("ld6", 1'b1, MODE_SQUARE, 1'b1, 6);
    for (int i = 0; i < 5; i++) step("run6", 1'b1, MODE_SQUARE, 1'b0, 0);
    chk("at_term_cnt", 32'(cnt), 32'd5);
    step("ld_term", 1'b1, MODE_SQUARE, 1'b1, 6);
    chk("ld_term_tick", 32'(tick), 32'd0);

    // Full-range divisor.
    step("ld15", 1'b1, MODE_PULSE, 1'b1, 15);
    for (int i = 0; i < 32; i++) step("div15", 1'b1, MODE_PULSE, 1'b0, 0);

    // Asynchronous reset mid-count at cnt=7.
    step("ld12", 1'b1, MODE_SQUARE, 1'b1, 12);
    for (int i = 0; i < 7; i++) step("run12", 1'b1, MODE_SQUARE, 1'b0, 0);
    chk("pre_rst_cnt", 32'(cnt), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) step("post_rst", 1'b1, MODE_PULSE, 1'b0, 0);

    // Randomized traffic.
    cur_mode = MODE_PULSE;
    for (int i = 0; i < 400; i++) begin
      logic e;
      logic l;
      int   d;
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) cur_mode = ~cur_mode;
      l = ($urandom_range(0, 14) == 0);
      d = int'($urandom_range(0, 15));
      step("rand", e, cur_mode, l, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 The module SHALL be parameterised by CNT_W, default 26, counter and divisor width in bits.
REQ-002 The module SHALL be parameterised by DIV_DEFAULT, default 50_000_000, the divisor in force after reset (1 Hz tick from 50 MHz).
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 en_i  input  1  count enable; low freezes the divider.
REQ-006 mode_i  input  1  0 = pulse mode (tick_o only), 1 = square mode (tick_o plus clk_o toggling).
REQ-007 load_i  input  1  one-cycle strobe; captures div_i and restarts the count.
REQ-008 div_i  input  CNT_W  new divisor, sampled only when load_i=1.
REQ-009 tick_o  output  1  registered one-cycle pulse at each terminal count.
REQ-010 clk_o  output  1  registered square wave, period 2*divisor cycles in square mode.
REQ-011 cnt_o  output  CNT_W  current count value, for display and debug.

Function
REQ-012 The internal divisor register div_q SHALL hold the active divisor; div_i SHALL have no effect unless load_i=1.
REQ-013 On load_i=1, div_q SHALL take max(div_i, 1): values 0 and 1 both mean tick every enabled cycle.
REQ-014 On load_i=1, cnt_o SHALL go to 0 and tick_o to 0; clk_o SHALL hold its value.
REQ-015 load_i SHALL take effect regardless of en_i.
REQ-016 With en_i=1 and no load, cnt_o SHALL step 0,1,...,div_q-1,0,... with one step per clock.
REQ-017 At the edge where cnt_o==div_q-1 with en_i=1, cnt_o SHALL wrap to 0 and tick_o SHALL be 1 for the following cycle.
REQ-018 Tick latency: with en_i held high from reset release, the first tick_o SHALL be high after the div_q-th rising edge; ticks repeat every div_q edges.
REQ-019 With div_q=1, tick_o SHALL stay continuously high while en_i=1.
REQ-020 In all other cycles tick_o SHALL be 0, including every cycle with en_i=0.
REQ-021 With en_i=0, cnt_o and clk_o SHALL hold; counting SHALL resume from the held value when en_i returns to 1.
REQ-022 In square mode, clk_o SHALL toggle on every edge that sets tick_o, giving a 50% duty square wave of period 2*div_q cycles.
REQ-023 In pulse mode, clk_o SHALL be driven to 0 at the next rising edge and held there.
REQ-024 On a mode_i change, the count SHALL continue undisturbed; when entering square mode, clk_o SHALL start at 0.
REQ-025 Load and terminal count in the same cycle SHALL resolve as load wins: no tick and no toggle.
REQ-026 If a loaded divisor is at or below the current cnt_o, no wrap-around error can arise, because load always clears the count (REQ-014).
REQ-027 Arithmetic: the terminal compare SHALL be performed at CNT_W bits; there SHALL be no overflow path, since cnt_o < div_q ≤ 2^CNT_W-1.

Reset
REQ-028 While rst_i=1, asynchronously: cnt_o=0, tick_o=0, clk_o=0, div_q=DIV_DEFAULT.
REQ-029 Reset asserted mid-count SHALL abort the current period; the first tick after release SHALL follow REQ-018 with DIV_DEFAULT.
REQ-030 Elaboration SHALL fail if DIV_DEFAULT is 0 or DIV_DEFAULT ≥ 2^CNT_W.

Structure
REQ-031 The package tick_gen_pkg SHALL hold the CNT_W default, DIV_1HZ_50MHZ = 50_000_000, and the mode encodings MODE_PULSE=0 and MODE_SQUARE=1.
REQ-032 The block SHALL be a single module with no sub-module; the counter, divisor register and output flops are too small to split.
REQ-033 All outputs SHALL be driven directly from flops, with no combinational path from any input to an output.

Verification
REQ-034 Reset sequence: reset, then en_i=1, load div_i=4, mode_i=0 -> tick_o high one cycle every 4 clocks; cnt_o follows 0,1,2,3,0; clk_o stays 0.
REQ-035 Square mode: div_q=3, mode_i=1 -> clk_o toggles every 3 clocks (period 6) and tick_o is coincident with each toggle edge.
REQ-036 Enable gating: div_q=5, drop en_i at cnt_o=2 for 7 cycles -> cnt_o holds at 2 and tick_o stays 0; after resume, the next tick comes 3 clocks later.
REQ-037 Load edge cases: load div_i=0 -> tick_o continuously high; load during the cnt_o==div_q-1 cycle -> no tick and cnt_o=0.
REQ-038 Async reset: assert rst_i mid-cycle at cnt_o=7 -> all outputs clear immediately without waiting for a clock edge, and div_q returns to DIV_DEFAULT.
REQ-039 Parameter check: CNT_W=4, DIV_DEFAULT=15 -> ticks every 15 cycles; load div_i=15 -> no overflow; DIV_DEFAULT=16 -> elaboration error.
